// File: rtl/fma_dot_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: FSM encoding and
// IEEE-754 single-precision special-exponent detection.
package fma_dot_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  function automatic logic is_special(input logic [31:0] x);
    return x[30:23] == EXP_SPECIAL;
  endfunction

endpackage

// File: rtl/fma_dot_sequencer_fma.sv
// Combinational single-precision fused multiply-add, D = A*B + C, with a
// single round-to-nearest-even step; NaN results are returned as the canonical quiet NaN.
module fma_dot_sequencer_fma (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  output logic [31:0] o_d
);
  import fma_dot_sequencer_pkg::*;

  localparam int FW = 99;

  logic               w_sp, w_sbig, w_ssml, w_sres, w_prod_big;
  logic               w_sticky, w_rnd, w_nan, w_pinf, w_cinf;
  logic [23:0]        w_ma, w_mb, w_mc;
  logic [22:0]        w_mant;
  logic [47:0]        w_prod, w_cext, w_mbig, w_msml;
  logic signed [12:0] w_ep, w_ec, w_ebig, w_d, w_er, w_sh;
  logic [FW-1:0]      w_big, w_sml, w_sum, w_norm;
  logic [6:0]         w_msb;
  logic [30:0]        w_packed;

  function automatic logic [23:0] sig(input logic [31:0] x);
    return {|x[30:23], x[22:0]};
  endfunction

  // Denormals share the minimum normal exponent.
  function automatic logic signed [12:0] bexp(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? 13'sd1 : $signed({5'd0, x[30:23]});
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_SPECIAL) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_SPECIAL) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic round_up(input logic lsb, input logic guard, input logic sticky);
    return guard && (sticky || lsb);
  endfunction

  always_comb begin
    w_sp   = i_a[31] ^ i_b[31];
    w_ma   = sig(i_a);
    w_mb   = sig(i_b);
    w_mc   = sig(i_c);
    w_prod = {24'd0, w_ma} * {24'd0, w_mb};
    w_cext = {1'b0, w_mc, 23'd0};
    w_ep   = bexp(i_a) + bexp(i_b) - 13'sd127;
    w_ec   = bexp(i_c);

    // Both operands are M * 2^(E-173); the one with the larger exponent anchors the frame.
    w_prod_big = (w_prod != 48'd0) && ((w_mc == 24'd0) || (w_ep >= w_ec));
    if (w_prod_big) begin
      w_mbig = w_prod; w_ebig = w_ep; w_sbig = w_sp;
      w_msml = w_cext; w_ssml = i_c[31]; w_d = w_ep - w_ec;
    end else begin
      w_mbig = w_cext; w_ebig = w_ec; w_sbig = i_c[31];
      w_msml = w_prod; w_ssml = w_sp; w_d = w_ec - w_ep;
    end

    w_big    = {1'b0, w_mbig, 50'd0};
    w_sml    = {1'b0, w_msml, 50'd0};
    w_sticky = 1'b0;
    if (w_d >= 13'sd99) begin
      w_sml = {{(FW-1){1'b0}}, |w_msml};
    end else begin
      w_sticky = |(w_sml << (7'd99 - w_d[6:0]));
      w_sml    = (w_sml >> w_d[6:0]) | {{(FW-1){1'b0}}, w_sticky};
    end

    if (w_sbig == w_ssml) begin
      w_sum = w_big + w_sml; w_sres = w_sbig;
    end else if (w_big >= w_sml) begin
      w_sum = w_big - w_sml; w_sres = w_sbig;
    end else begin
      w_sum = w_sml - w_big; w_sres = w_ssml;
    end

    w_msb = 7'd0;
    for (int i = 0; i < FW; i++) begin
      if (w_sum[i]) w_msb = 7'(i);
    end

    // Normalise so the leading one lands on bit 98, or clamp to the denormal exponent.
    w_er = $signed({6'd0, w_msb}) + w_ebig - 13'sd96;
    w_sh = 13'sd98 - $signed({6'd0, w_msb});
    if (w_er < 13'sd1) begin
      w_sh = w_ebig + 13'sd1;
      w_er = 13'sd0;
    end
    w_norm   = (w_sh < 13'sd0) ? '0 : (w_sum << w_sh[6:0]);
    w_mant   = w_norm[97:75];
    w_rnd    = round_up(w_norm[75], w_norm[74], |w_norm[73:0]);
    w_packed = {w_er[7:0], w_mant} + {30'd0, w_rnd};

    w_pinf = is_inf(i_a) || is_inf(i_b);
    w_cinf = is_inf(i_c);
    w_nan  = is_nan(i_a) || is_nan(i_b) || is_nan(i_c) ||
             (is_inf(i_a) && (i_b[30:0] == 31'd0)) ||
             (is_inf(i_b) && (i_a[30:0] == 31'd0)) ||
             (w_pinf && w_cinf && (w_sp != i_c[31]));

    if (w_nan)                 o_d = 32'h7FC00000;
    else if (w_pinf)           o_d = {w_sp, EXP_SPECIAL, 23'd0};
    else if (w_cinf)           o_d = {i_c[31], EXP_SPECIAL, 23'd0};
    else if (w_sum == '0)      o_d = {w_sp & i_c[31], 31'd0};
    else if (w_er >= 13'sd255) o_d = {w_sres, EXP_SPECIAL, 23'd0};
    else                       o_d = {w_sres, w_packed};
  end

endmodule

// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer: streams (a, b) pairs through the combinational FMA,
// feeding the running sum back as the addend, and emits one result per command.
module fma_dot_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_special
);
  import fma_dot_sequencer_pkg::*;

  state_e           r_state;
  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_remaining;
  logic             r_special;

  logic             w_in_accum;
  logic [31:0]      w_fma_a, w_fma_b, w_fma_c, w_fma_d;

  // Zero the FMA operands outside ACCUM so D stays quiet.
  assign w_in_accum = (r_state == ACCUM);
  assign w_fma_a    = w_in_accum ? in_a  : 32'd0;
  assign w_fma_b    = w_in_accum ? in_b  : 32'd0;
  assign w_fma_c    = w_in_accum ? r_acc : 32'd0;

  fma_dot_sequencer_fma u_fma (
    .i_a (w_fma_a),
    .i_b (w_fma_b),
    .i_c (w_fma_c),
    .o_d (w_fma_d)
  );

  assign cmd_ready   = (r_state == IDLE) && !flush && !rst;
  assign in_ready    = w_in_accum && !rst;
  assign out_valid   = (r_state == DONE) && !rst;
  assign out_data    = r_acc;
  assign out_special = r_special;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 32'd0;
      r_remaining <= '0;
      r_special   <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_special   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_acc       <= cmd_init;
            r_remaining <= cmd_len;
            r_special   <= is_special(cmd_init);
            r_state     <= (cmd_len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_acc       <= w_fma_d;
            r_remaining <= r_remaining - LEN_W'(1);
            r_special   <= r_special | is_special(in_a) | is_special(in_b);
            if (r_remaining == LEN_W'(1)) r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Bench for fma_dot_sequencer: table of dot-product commands with hand-computed
// IEEE results, scoreboard queue, plus flush and reset sequences.
module tb_fma_dot_sequencer;
  localparam int LEN_W = 8;
  localparam int NV    = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0]      cmd_init = 32'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = 32'd0;
  logic [31:0]      in_b = 32'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             out_special;

  always #5 clk = ~clk;

  fma_dot_sequencer #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_init    (cmd_init),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_special (out_special)
  );

  typedef struct packed {
    logic [31:0]      init;
    logic [7:0]       len;
    logic [2:0][31:0] a;
    logic [2:0][31:0] b;
    logic             gap;
    logic [3:0]       stall;
    logic [31:0]      exp_d;
    logic             exp_s;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] init, input logic [7:0] len,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input logic [31:0] a2, input logic [31:0] b2,
                              input logic gap, input logic [3:0] stall,
                              input logic [31:0] exp_d, input logic exp_s);
    vec_t v;
    v.init = init; v.len = len;
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1; v.a[2] = a2; v.b[2] = b2;
    v.gap = gap; v.stall = stall; v.exp_d = exp_d; v.exp_s = exp_s;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   k, n;
    logic hs, early;
    cmd_init  = v.init;
    cmd_len   = v.len;
    cmd_valid = 1'b1;
    e.d = v.exp_d; e.s = v.exp_s;
    sb.push_back(e);
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk1($sformatf("v%0d cmd_ready", idx), cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    k = 0; n = 0; early = 1'b0;
    while (k < int'(v.len) && n < 100) begin
      in_valid = v.gap ? n[0] : 1'b1;
      in_a = v.a[k];
      in_b = v.b[k];
      #1;
      hs = in_valid && in_ready;
      early |= out_valid;
      step();
      n++;
      if (hs) k++;
    end
    in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
    chk($sformatf("v%0d elements", idx), k, 32'(v.len));
    chk1($sformatf("v%0d early out_valid", idx), early, 1'b0);
    chk1($sformatf("v%0d out_valid latency", idx), out_valid, 1'b1);
    if (v.len == 8'd0) chk1($sformatf("v%0d in_ready len0", idx), in_ready, 1'b0);
    for (int s = 0; s < int'(v.stall); s++) begin
      chk($sformatf("v%0d stall data", idx), out_data, sb[0].d);
      chk1($sformatf("v%0d stall cmd_ready", idx), cmd_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    e = sb.pop_front();
    chk($sformatf("v%0d out_data", idx), out_data, e.d);
    chk1($sformatf("v%0d out_special", idx), out_special, e.s);
    step();
    out_ready = 1'b0;
    chk1($sformatf("v%0d out_valid after hs", idx), out_valid, 1'b0);
    chk1($sformatf("v%0d cmd_ready after hs", idx), cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(32'h00000000, 8'd2, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h41000000, 1'b0);
    vecs[1]  = mk(32'h40400000, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b0, 4'd1, 32'h40400000, 1'b0);
    vecs[2]  = mk(32'h3F800000, 8'd3, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h40800000,
                  32'hBF800000, 32'h3F800000, 1'b1, 4'd5, 32'h40C00000, 1'b0);
    vecs[3]  = mk(32'h00000000, 8'd2, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h7F800000, 1'b1);
    vecs[4]  = mk(32'h00000000, 8'd1, 32'h3FC00000, 32'h40000000, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h40400000, 1'b0);
    vecs[5]  = mk(32'hC0000000, 8'd2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h00000000, 1'b0);
    vecs[6]  = mk(32'h7FC00000, 8'd1, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h7FC00000, 1'b1);
    vecs[7]  = mk(32'hBF800000, 8'd1, 32'h3F800001, 32'h3F800001, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h34800000, 1'b0);
    vecs[8]  = mk(32'h00000000, 8'd1, 32'h7F000000, 32'h40000000, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h7F800000, 1'b0);
    vecs[9]  = mk(32'h00000000, 8'd1, 32'hC0000000, 32'h40400000, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b1, 4'd2, 32'hC0C00000, 1'b0);
    vecs[10] = mk(32'h3F800000, 8'd1, 32'h3F800001, 32'h3F800001, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b0, 4'd0, 32'h40000001, 1'b0);

    // Reset state
    step();
    step();
    chk1("rst cmd_ready", cmd_ready, 1'b0);
    chk1("rst in_ready", in_ready, 1'b0);
    chk1("rst out_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post-rst cmd_ready", cmd_ready, 1'b1);
    chk("post-rst out_data", out_data, 32'h00000000);
    chk1("post-rst out_special", out_special, 1'b0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Flush mid-command, coincident with an offered element
    cmd_init = 32'h00000000; cmd_len = 8'd4; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
    step();
    flush = 1'b1;
    #1;
    chk1("flush in_ready before", in_ready, 1'b1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk1("flush cmd_ready", cmd_ready, 1'b1);
    chk1("flush in_ready", in_ready, 1'b0);
    chk1("flush out_valid", out_valid, 1'b0);
    flush = 1'b1;
    #1;
    chk1("flush masks cmd_ready", cmd_ready, 1'b0);
    step();
    flush = 1'b0;
    #1;
    run_vec(mk(32'h3F800000, 8'd1, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0,
               32'h0, 32'h0, 1'b0, 4'd0, 32'h40000000, 1'b0), 100);

    // Reset while holding a result in DONE
    cmd_init = 32'h40400000; cmd_len = 8'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk1("rst-seq out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rst-seq during out_valid", out_valid, 1'b0);
    chk1("rst-seq during cmd_ready", cmd_ready, 1'b0);
    chk1("rst-seq during in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk1("rst-seq after out_valid", out_valid, 1'b0);
    chk1("rst-seq after cmd_ready", cmd_ready, 1'b1);
    chk("rst-seq after out_data", out_data, 32'h00000000);
    chk1("rst-seq after out_special", out_special, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
